// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: round-robin controller for a 4-bit bank of master-slave SR
// flip-flops. Two requesters (A, B) each issue set / clear / toggle / no-op
// on a single bit. Each operation runs IDLE -> APPLY -> CHECK. The controller
// then reads the bank back and compares it with the value it expects.
//
// Ports
//   Clk                 single clock, rising edge
//   Rst                 asynchronous active-high reset
//   ReqA/OpA/AddrA      requester A: level request, op (00 set, 01 clear,
//                       10 toggle, 11 no-op), target bit index
//   ReqB/OpB/AddrB      requester B, same meaning
//   AckA/AckB           one-cycle completion pulse per requester
//   Err                 one-cycle pulse with Ack on readback mismatch
//   Busy                high in every state except IDLE
//   Q                   bank contents

// sr_ff: positive-edge master-slave SR flip-flop.
// The next-state gates (S | ~R & Q) feed a master latch that is transparent
// while Clk is low. The slave stage takes the master value on the rising
// edge. Qm exposes the master stage, which already holds the value Q will
// take at the coming edge.
module sr_ff (
  input  logic Clk,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Qm
);
  logic r_n_s;
  logic hold_s;
  logic d_s;
  logic m_r;
  logic q_r;

  not u_rn   (r_n_s, R);
  and u_hold (hold_s, r_n_s, q_r);
  or  u_d    (d_s, S, hold_s);

  // master latch, open during the low phase of Clk
  always_latch begin
    if (!Clk) m_r <= d_s;
  end

  // slave stage, updates on the rising edge of Clk
  always_ff @(posedge Clk) begin
    q_r <= m_r;
  end

  assign Q  = q_r;
  assign Qm = m_r;
endmodule

module sr_bank_ctrl (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       ReqA,
  input  logic [1:0] OpA,
  input  logic [1:0] AddrA,
  input  logic       ReqB,
  input  logic [1:0] OpB,
  input  logic [1:0] AddrB,
  output logic       AckA,
  output logic       AckB,
  output logic       Err,
  output logic       Busy,
  output logic [3:0] Q
);
  typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, APPLY = 2'd2, CHECK = 2'd3} state_t;

  state_t     state_r, next_s;
  logic [1:0] op_r, op_next_s;
  logic [1:0] addr_r, addr_next_s;
  logic       win_r, win_next_s;     // 0 = A, 1 = B
  logic       last_r, last_next_s;   // last granted requester, 1 = B
  logic       qbit_r, qbit_next_s;   // Q[addr] sampled at grant
  logic [3:0] s_r, s_next_s;
  logic [3:0] r_r, r_next_s;
  logic       acka_r, acka_next_s;
  logic       ackb_r, ackb_next_s;
  logic       err_r, err_next_s;
  logic       busy_r;

  logic       grant_b_s;
  logic [1:0] sel_op_s;
  logic [1:0] sel_addr_s;
  logic       sel_q_s;
  logic       exp_s;
  logic       init_s;
  logic [3:0] s_bank_s;
  logic [3:0] r_bank_s;
  logic [3:0] q_s;
  logic [3:0] qm_s;

  // B wins only when A is idle or A was granted last.
  assign grant_b_s  = ReqB & (~ReqA | ~last_r);
  assign sel_op_s   = grant_b_s ? OpB : OpA;
  assign sel_addr_s = grant_b_s ? AddrB : AddrA;
  assign sel_q_s    = q_s[sel_addr_s];

  // The clear pulse comes straight from the INIT state. The bank has no reset
  // of its own, and the S/R registers must read zero while Rst is held.
  // Gating with ~Rst keeps R low during reset. R is high only for the single
  // INIT cycle that follows release.
  assign init_s   = (state_r == INIT) & ~Rst;
  assign s_bank_s = s_r;
  assign r_bank_s = r_r | {4{init_s}};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      sr_ff u_ff (
        .Clk (Clk),
        .S   (s_bank_s[gi]),
        .R   (r_bank_s[gi]),
        .Q   (q_s[gi]),
        .Qm  (qm_s[gi])
      );
    end
  endgenerate

  // expected readback for the latched operation
  always_comb begin
    exp_s = qbit_r;
    case (op_r)
      2'b00:   exp_s = 1'b1;
      2'b01:   exp_s = 1'b0;
      2'b10:   exp_s = ~qbit_r;
      default: exp_s = qbit_r;
    endcase
  end

  // next-state and next-output logic
  always_comb begin
    next_s      = state_r;
    op_next_s   = op_r;
    addr_next_s = addr_r;
    win_next_s  = win_r;
    last_next_s = last_r;
    qbit_next_s = qbit_r;
    s_next_s    = 4'b0000;
    r_next_s    = 4'b0000;
    acka_next_s = 1'b0;
    ackb_next_s = 1'b0;
    err_next_s  = 1'b0;
    case (state_r)
      INIT: next_s = IDLE;
      IDLE: begin
        if (ReqA | ReqB) begin
          next_s      = APPLY;
          win_next_s  = grant_b_s;
          last_next_s = grant_b_s;
          op_next_s   = sel_op_s;
          addr_next_s = sel_addr_s;
          qbit_next_s = sel_q_s;
          // S/R are loaded here so that they are stable for the whole APPLY cycle.
          case (sel_op_s)
            2'b00:   s_next_s[sel_addr_s] = 1'b1;
            2'b01:   r_next_s[sel_addr_s] = 1'b1;
            2'b10: begin
              s_next_s[sel_addr_s] = ~sel_q_s;
              r_next_s[sel_addr_s] = sel_q_s;
            end
            default: s_next_s = 4'b0000;
          endcase
        end else begin
          next_s = IDLE;
        end
      end
      APPLY: begin
        next_s      = CHECK;
        acka_next_s = ~win_r;
        ackb_next_s = win_r;
        // The master stage holds the post-operation bit at this edge, so the
        // readback and the Ack can be registered together.
        err_next_s  = (qm_s[addr_r] != exp_s);
      end
      CHECK: next_s = IDLE;
      default: next_s = INIT;
    endcase
  end

  // controller state and registered outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= INIT;
      op_r    <= 2'b00;
      addr_r  <= 2'b00;
      win_r   <= 1'b0;
      last_r  <= 1'b1;
      qbit_r  <= 1'b0;
      s_r     <= 4'b0000;
      r_r     <= 4'b0000;
      acka_r  <= 1'b0;
      ackb_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b1;
    end else begin
      state_r <= next_s;
      op_r    <= op_next_s;
      addr_r  <= addr_next_s;
      win_r   <= win_next_s;
      last_r  <= last_next_s;
      qbit_r  <= qbit_next_s;
      s_r     <= s_next_s;
      r_r     <= r_next_s;
      acka_r  <= acka_next_s;
      ackb_r  <= ackb_next_s;
      err_r   <= err_next_s;
      busy_r  <= (next_s != IDLE);
    end
  end

  assign AckA = acka_r;
  assign AckB = ackb_r;
  assign Err  = err_r;
  assign Busy = busy_r;
  assign Q    = q_s;
endmodule
